cpu_sequencer: RTL and testbench
================================

// Module: cpu_sequencer
// PURPOSE
//  Multi-cycle control FSM for the 8-bit CPU. Owns the PC and two instruction bytes (IR1, IR2).
//  Fetches each 2-byte instruction from ROM one byte per cycle and decodes it.
//  Sequences RAM strobes, register-file write, ALU enable and flag capture for one instruction at a time.
//  Sits between the ROM and the Datapath; it replaces the combinational Controller and the free-running PC.
// PARAMETERS
//  RESET_VECTOR  8'h00  PC value loaded on reset
//  MEM_WAIT      0      extra cycles the RAM read/write strobes are held (0..15)
// PORTS
//  clk          in   1  system clock; all state updates on posedge
//  reset        in   1  synchronous, active-high
//  run          in   1  1 = execute; 0 = stop at the next instruction boundary
//  rom_data     in   8  ROM byte at rom_address (combinational ROM)
//  carry_in     in   1  ALU Carry_f, valid during EXEC of an ALU op
//  zero_in      in   1  ALU Zero_f, valid during EXEC of an ALU op
//  rom_address  out  8  current PC
//  ir1, ir2     out  8  latched instruction bytes to the datapath
//  n_cs,n_oe,n_we out 1 each  RAM strobes, active-low
//  reg_write    out  1  one-cycle register-file write enable; destination is ir1[2:0]
//  mem_to_reg   out  2  00 = IR2 immediate, 01 = RAM, 10 = ALU, 11 = none
//  alu_op       out  1  ALU enable
//  alu_func     out  3  = ir1[6:4]
//  carry_q,zero_q out 1 each  latched flags
//  busy         out  1  high in any state other than IDLE or HALT
//  halted       out  1  high in HALT
//  instr_done   out  1  one-cycle pulse on the last cycle of each instruction
// BEHAVIOUR
//  Reset: state = IDLE; pc = RESET_VECTOR; ir1 = ir2 = 0; flags = 0.
//   Strobes inactive: n_cs = n_oe = n_we = 1; reg_write = alu_op = 0; mem_to_reg = 11.
//   busy = halted = instr_done = 0. Reset has priority in every state, including mid-instruction.
//  States: IDLE, FETCH1, FETCH2, EXEC, MEM, HALT.
//   IDLE   -> FETCH1 when run = 1; otherwise stay in IDLE.
//   FETCH1: ir1 <= rom_data; pc <= pc + 1.
//   FETCH2: ir2 <= rom_data; pc <= pc + 1. -> EXEC
//   EXEC: decoded on ir1[7:4]:
//    0000 NOP:   instr_done.
//    0001 LDI:   mem_to_reg = 00, reg_write = 1.
//    0010 LD:    n_cs = 0, n_oe = 0 for MEM_WAIT+1 cycles (address = ir2). -> MEM
//    0011 ST:    n_cs = 0, n_we = 0 (n_oe = 1) for MEM_WAIT+1 cycles. Last cycle is instr_done.
//    0100 JMP:   cond = ir1[2:0]:
//                 000 = always
//                 x01 = carry_q, inverted if ir1[2] = 1
//                 x10 = zero_q, inverted if ir1[2] = 1
//                 011 / 111 = never (NOP)
//                if cond: pc <= ir2.
//    0101 HALT:  -> HALT.
//    1fff ALU:   alu_op = 1, mem_to_reg = 10, reg_write = 1; carry_q <= carry_in, zero_q <= zero_in.
//    0110, 0111: reserved, executed as NOP.
//   MEM (LD only): mem_to_reg = 01, n_cs = n_oe = 0 held; reg_write = 1; instr_done.
//   After instr_done: -> FETCH1 if run = 1, else -> IDLE.
//   HALT: stay until reset; pc holds the address after the HALT instruction.
//  Latency: 3 cycles for NOP/LDI/ALU/JMP; 3+MEM_WAIT for ST; 4+MEM_WAIT for LD.
//  PC arithmetic is 8-bit modulo: pc = 8'hFF increments to 8'h00.
//   An instruction at FE/FF fetches cleanly. An instruction at FF fetches its second byte from 00.
//  Flags change only on ALU ops; JMP reads the pre-instruction flags.
//  Deasserting run mid-instruction never aborts the instruction; it completes first.
//  Strobes are combinational from state and ir1. They are never active in IDLE, FETCH1, FETCH2 or HALT.
// STRUCTURE
//  cpu_pkg: state enum; opcode constants (OP_NOP..OP_ALU); mem_to_reg encodings; JMP condition codes.
//  Sub-module cpu_jump_eval: combinational (ir1[2:0], carry_q, zero_q) -> take_jump.
//  Wait counter: 4-bit, loaded with MEM_WAIT on EXEC entry.
// TESTING
//  ROM {10 03, 10 05, 80 34, 50 00}, run = 1:
//   -> two LDI writes, then reg_write with alu_func = 000.
//   -> Ends in HALT with halted = 1, rom_address = 08.
//  LD with ir2 = 8'h20, MEM_WAIT = 2:
//   -> n_cs = n_oe = 0 for 4 cycles; reg_write in the last cycle; 6 cycles total.
//  ALU op giving zero, then 42 10 (JZ 0x10):
//   -> pc = 10 after the JMP.
//   -> 46 10 (JNZ) does not jump; pc advances by 2.
//  Program starting at FE: fetch addresses FE, FF, then 00; no X on rom_address.
//  run dropped in FETCH2 of ST:
//   -> ST completes (n_we low 1 cycle), then IDLE with busy = 0.
//   -> run = 1 resumes at the next PC.
//  reset asserted during an LD MEM cycle:
//   -> next cycle IDLE, pc = RESET_VECTOR, all strobes inactive, no reg_write.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and encodings for the multi-cycle CPU sequencer.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH1,
        S_FETCH2,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_JMP  = 4'h4;
    localparam logic [3:0] OP_HALT = 4'h5;
    localparam logic [3:0] OP_ALU  = 4'h8;  // any opcode with bit 7 set

    localparam logic [1:0] M2R_IMM  = 2'b00;
    localparam logic [1:0] M2R_RAM  = 2'b01;
    localparam logic [1:0] M2R_ALU  = 2'b10;
    localparam logic [1:0] M2R_NONE = 2'b11;

    // Low two bits of the JMP condition; bit 2 inverts the sense.
    localparam logic [1:0] JC_ALWAYS = 2'b00;
    localparam logic [1:0] JC_CARRY  = 2'b01;
    localparam logic [1:0] JC_ZERO   = 2'b10;
    localparam logic [1:0] JC_NEVER  = 2'b11;

endpackage

// File: rtl/cpu_jump_eval.sv
// Combinational JMP condition evaluation against the latched flags.
module cpu_jump_eval
    import cpu_pkg::*;
(
    input  logic [2:0] cond_i,
    input  logic       carry_i,
    input  logic       zero_i,
    output logic       take_o
);

    // Code 011/111 never jumps, so the inversion bit cannot turn it into "always".
    always_comb begin
        take_o = 1'b0;
        case (cond_i[1:0])
            JC_ALWAYS: take_o = ~cond_i[2];
            JC_CARRY:  take_o = carry_i ^ cond_i[2];
            JC_ZERO:   take_o = zero_i ^ cond_i[2];
            default:   take_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute control FSM: owns PC, IR1/IR2 and the flags,
// and drives RAM strobes, register write, ALU enable and mem_to_reg select.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter logic [7:0]  RESET_VECTOR = 8'h00,
    parameter int unsigned MEM_WAIT     = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [7:0] rom_data,
    input  logic       carry_in,
    input  logic       zero_in,
    output logic [7:0] rom_address,
    output logic [7:0] ir1,
    output logic [7:0] ir2,
    output logic       n_cs,
    output logic       n_oe,
    output logic       n_we,
    output logic       reg_write,
    output logic [1:0] mem_to_reg,
    output logic       alu_op,
    output logic [2:0] alu_func,
    output logic       carry_q,
    output logic       zero_q,
    output logic       busy,
    output logic       halted,
    output logic       instr_done
);

    localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

    state_t     state_q;
    logic [7:0] pc_q, ir1_q, ir2_q;
    logic       cflag_q, zflag_q;
    logic [3:0] wait_q;

    logic [3:0] op;
    logic       is_alu, wait_done, take_jump;

    assign op        = ir1_q[7:4];
    assign is_alu    = ir1_q[7];
    assign wait_done = (wait_q == 4'd0);

    cpu_jump_eval u_jump (
        .cond_i  (ir1_q[2:0]),
        .carry_i (cflag_q),
        .zero_i  (zflag_q),
        .take_o  (take_jump)
    );

    // Strobes and enables decode straight from state and IR1.
    always_comb begin
        n_cs       = 1'b1;
        n_oe       = 1'b1;
        n_we       = 1'b1;
        reg_write  = 1'b0;
        mem_to_reg = M2R_NONE;
        alu_op     = 1'b0;
        instr_done = 1'b0;
        case (state_q)
            S_EXEC: begin
                if (is_alu) begin
                    alu_op     = 1'b1;
                    mem_to_reg = M2R_ALU;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end else begin
                    case (op)
                        OP_LDI: begin
                            mem_to_reg = M2R_IMM;
                            reg_write  = 1'b1;
                            instr_done = 1'b1;
                        end
                        OP_LD: begin
                            n_cs = 1'b0;
                            n_oe = 1'b0;
                        end
                        OP_ST: begin
                            n_cs       = 1'b0;
                            n_we       = 1'b0;
                            instr_done = wait_done;
                        end
                        OP_HALT: instr_done = 1'b0;
                        default: instr_done = 1'b1;
                    endcase
                end
            end
            S_MEM: begin
                n_cs       = 1'b0;
                n_oe       = 1'b0;
                mem_to_reg = M2R_RAM;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_VECTOR;
            ir1_q   <= '0;
            ir2_q   <= '0;
            cflag_q <= 1'b0;
            zflag_q <= 1'b0;
            wait_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (run) state_q <= S_FETCH1;
                S_FETCH1: begin
                    ir1_q   <= rom_data;
                    pc_q    <= pc_q + 8'd1;
                    state_q <= S_FETCH2;
                end
                S_FETCH2: begin
                    ir2_q   <= rom_data;
                    pc_q    <= pc_q + 8'd1;
                    wait_q  <= WAIT_INIT;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    if (instr_done) state_q <= run ? S_FETCH1 : S_IDLE;
                    if (is_alu) begin
                        cflag_q <= carry_in;
                        zflag_q <= zero_in;
                    end else if (op == OP_JMP) begin
                        if (take_jump) pc_q <= ir2_q;
                    end else if (op == OP_HALT) begin
                        state_q <= S_HALT;
                    end else if (op == OP_LD) begin
                        if (wait_done) state_q <= S_MEM;
                        else           wait_q  <= wait_q - 4'd1;
                    end else if (op == OP_ST && !wait_done) begin
                        wait_q <= wait_q - 4'd1;
                    end
                end
                S_MEM:   state_q <= run ? S_FETCH1 : S_IDLE;
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rom_address = pc_q;
    assign ir1         = ir1_q;
    assign ir2         = ir2_q;
    assign alu_func    = ir1_q[6:4];
    assign carry_q     = cflag_q;
    assign zero_q      = zflag_q;
    assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: per-instruction cycle-trace model plus directed programs.
module tb_cpu_sequencer;

    localparam int unsigned MW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, run, carry_in, zero_in;
    logic [7:0] rom_data, rom_address, ir1, ir2;
    logic       n_cs, n_oe, n_we, reg_write, alu_op, carry_q, zero_q;
    logic       busy, halted, instr_done;
    logic [1:0] mem_to_reg;
    logic [2:0] alu_func;

    logic [7:0] rom [256];
    assign rom_data = rom[rom_address];

    cpu_sequencer #(.RESET_VECTOR(8'h00), .MEM_WAIT(MW)) dut (
        .clk(clk), .reset(reset), .run(run), .rom_data(rom_data),
        .carry_in(carry_in), .zero_in(zero_in), .rom_address(rom_address),
        .ir1(ir1), .ir2(ir2), .n_cs(n_cs), .n_oe(n_oe), .n_we(n_we),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_op(alu_op),
        .alu_func(alu_func), .carry_q(carry_q), .zero_q(zero_q),
        .busy(busy), .halted(halted), .instr_done(instr_done)
    );

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] i1;
        logic [7:0] i2;
        logic [2:0] fn;
        logic       cs, oe, we, rw;
        logic [1:0] m2r;
        logic       alu, cq, zq, bsy, hlt, done;
    } obs_t;

    typedef struct {
        obs_t       o;
        bit         cap;
        bit         last;
        bit         to_halt;
        logic [7:0] npc;
    } rec_t;

    rec_t       q[$];
    logic [7:0] m_pc, m_ir1, m_ir2;
    bit         m_c, m_z, m_halted;
    bit         chk_on = 0;
    int unsigned checks = 0, passed = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    endtask

    function automatic obs_t quiet(input logic [7:0] a, input logic [7:0] i1,
                                   input logic [7:0] i2, input bit bsy, input bit hlt);
        obs_t o;
        o.addr = a; o.i1 = i1; o.i2 = i2; o.fn = i1[6:4];
        o.cs = 1; o.oe = 1; o.we = 1; o.rw = 0; o.m2r = 2'b11; o.alu = 0;
        o.cq = m_c; o.zq = m_z; o.bsy = bsy; o.hlt = hlt; o.done = 0;
        return o;
    endfunction

    function automatic bit jmp_taken(input logic [2:0] cc);
        case (cc)
            3'd0: return 1'b1;
            3'd1: return m_c;
            3'd5: return !m_c;
            3'd2: return m_z;
            3'd6: return !m_z;
            default: return 1'b0;
        endcase
    endfunction

    // Queue the whole expected cycle trace of the instruction at m_pc.
    task automatic build();
        logic [7:0] p, b1, b2;
        rec_t r;
        p  = m_pc;
        b1 = rom[p];
        b2 = rom[8'(p + 8'd1)];
        r.cap = 0; r.last = 0; r.to_halt = 0; r.npc = 8'(p + 8'd2);
        r.o = quiet(p, m_ir1, m_ir2, 1, 0);                q.push_back(r);
        r.o = quiet(8'(p + 8'd1), b1, m_ir2, 1, 0);        q.push_back(r);
        r.o = quiet(8'(p + 8'd2), b1, b2, 1, 0);
        if (b1[7]) begin
            r.o.alu = 1; r.o.m2r = 2'b10; r.o.rw = 1; r.o.done = 1;
            r.cap = 1; r.last = 1; q.push_back(r);
        end else begin
            case (b1[7:4])
                4'h1: begin
                    r.o.m2r = 2'b00; r.o.rw = 1; r.o.done = 1; r.last = 1; q.push_back(r);
                end
                4'h2: begin
                    r.o.cs = 0; r.o.oe = 0;
                    for (int unsigned i = 0; i <= MW; i++) q.push_back(r);
                    r.o.m2r = 2'b01; r.o.rw = 1; r.o.done = 1; r.last = 1; q.push_back(r);
                end
                4'h3: begin
                    r.o.cs = 0; r.o.we = 0;
                    for (int unsigned i = 0; i <= MW; i++) begin
                        r.o.done = (i == MW); r.last = (i == MW); q.push_back(r);
                    end
                end
                4'h4: begin
                    if (jmp_taken(b1[2:0])) r.npc = b2;
                    r.o.done = 1; r.last = 1; q.push_back(r);
                end
                4'h5: begin
                    r.to_halt = 1; r.last = 1; q.push_back(r);
                end
                default: begin
                    r.o.done = 1; r.last = 1; q.push_back(r);
                end
            endcase
        end
    endtask

    // One clock: drive, compare against the model, advance the model.
    task automatic step(input bit rs, input bit rn, input bit ci, input bit zi);
        obs_t act, exp;
        rec_t r;
        reset = rs; run = rn; carry_in = ci; zero_in = zi;
        #1;
        act = {rom_address, ir1, ir2, alu_func, n_cs, n_oe, n_we, reg_write,
               mem_to_reg, alu_op, carry_q, zero_q, busy, halted, instr_done};
        if (chk_on) begin
            exp = (q.size() != 0) ? q[0].o : quiet(m_pc, m_ir1, m_ir2, 0, m_halted);
            chk("cycle", 64'(act), 64'(exp));
        end
        if (rs) begin
            q.delete();
            m_pc = 8'h00; m_ir1 = '0; m_ir2 = '0; m_c = 0; m_z = 0; m_halted = 0;
            chk_on = 1;
        end else if (q.size() != 0) begin
            r = q.pop_front();
            if (r.cap) begin m_c = ci; m_z = zi; end
            if (r.last) begin
                m_pc = r.npc; m_ir1 = r.o.i1; m_ir2 = r.o.i2;
                if (r.to_halt) m_halted = 1;
            end
            if (r.o.done && rn) build();
        end else if (!m_halted && rn) begin
            build();
        end
        @(negedge clk);
    endtask

    task automatic clr_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    endtask

    task automatic run_to_halt(input bit ci, input bit zi);
        for (int n = 0; n < 60 && !halted; n++) step(0, 1, ci, zi);
        chk("halt_reached", 64'(halted), 64'd1);
    endtask

    int unsigned nrw, ncs, nwe, len;
    logic [1:0]  m2r_log [3];
    logic [2:0]  fn_last;
    bit          got, rwl, saw_ff, wrapped;
    logic [7:0]  jc_tab [7] = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h45, 8'h46, 8'h47};

    initial begin
        // LDI, LDI, ALU, HALT
        clr_rom();
        rom[0] = 8'h10; rom[1] = 8'h03; rom[2] = 8'h10; rom[3] = 8'h05;
        rom[4] = 8'h80; rom[5] = 8'h34; rom[6] = 8'h50; rom[7] = 8'h00;
        step(1, 0, 0, 0);
        chk("reset_pc", 64'(rom_address), 64'h00);
        chk("reset_strobes", 64'({n_cs, n_oe, n_we, reg_write, alu_op}), 64'b11100);
        chk("reset_m2r", 64'(mem_to_reg), 64'd3);
        chk("reset_status", 64'({busy, halted, instr_done}), 64'd0);
        nrw = 0; fn_last = 3'd7;
        for (int n = 0; n < 40 && !halted; n++) begin
            if (reg_write) begin
                if (nrw < 3) m2r_log[nrw] = mem_to_reg;
                nrw++; fn_last = alu_func;
            end
            step(0, 1, 0, 0);
        end
        chk("prog1_halted", 64'(halted), 64'd1);
        chk("prog1_pc", 64'(rom_address), 64'h08);
        chk("prog1_writes", 64'(nrw), 64'd3);
        chk("prog1_m2r", 64'({m2r_log[0], m2r_log[1], m2r_log[2]}), 64'b000010);
        chk("prog1_func", 64'(fn_last), 64'd0);

        // LD 0x20 with MEM_WAIT=2
        clr_rom();
        rom[0] = 8'h20; rom[1] = 8'h20; rom[2] = 8'h50;
        step(1, 0, 0, 0);
        len = 0; ncs = 0; got = 0; rwl = 0;
        for (int n = 0; n < 40 && !halted; n++) begin
            if (busy && !got) len++;
            if (!n_cs) ncs++;
            if (instr_done && !got) begin got = 1; rwl = reg_write; end
            step(0, 1, 0, 0);
        end
        chk("ld_cs_cycles", 64'(ncs), 64'd4);
        chk("ld_length", 64'(len), 64'd6);
        chk("ld_write_last", 64'(rwl), 64'd1);

        // ALU giving zero, then JZ 0x10
        clr_rom();
        rom[0] = 8'h80; rom[2] = 8'h42; rom[3] = 8'h10; rom[4] = 8'h50; rom[8'h10] = 8'h50;
        step(1, 0, 0, 0);
        run_to_halt(0, 1);
        chk("jz_pc", 64'(rom_address), 64'h12);
        chk("jz_zero", 64'(zero_q), 64'd1);

        // JNZ not taken
        rom[2] = 8'h46;
        step(1, 0, 0, 0);
        run_to_halt(0, 1);
        chk("jnz_pc", 64'(rom_address), 64'h06);

        // Instruction at FE wraps to 00
        clr_rom();
        rom[0] = 8'h41; rom[1] = 8'h04; rom[2] = 8'h40; rom[3] = 8'hFE;
        rom[4] = 8'h50; rom[8'hFE] = 8'h80;
        step(1, 0, 0, 0);
        saw_ff = 0; wrapped = 0;
        for (int n = 0; n < 60 && !halted; n++) begin
            if (rom_address == 8'hFF) saw_ff = 1;
            else if (saw_ff && rom_address == 8'h00) wrapped = 1;
            step(0, 1, 1, 0);
        end
        chk("wrap_seen", 64'({saw_ff, wrapped}), 64'b11);
        chk("wrap_pc", 64'(rom_address), 64'h06);

        // run dropped in FETCH2 of ST
        clr_rom();
        rom[0] = 8'h30; rom[1] = 8'h40; rom[2] = 8'h10; rom[3] = 8'h01; rom[4] = 8'h50;
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        nwe = 0;
        for (int n = 0; n < 8; n++) begin
            if (!n_we) nwe++;
            step(0, 0, 0, 0);
        end
        chk("st_we_cycles", 64'(nwe), 64'(MW + 1));
        chk("st_idle", 64'({busy, halted}), 64'd0);
        chk("st_idle_pc", 64'(rom_address), 64'h02);
        step(0, 1, 0, 0);
        chk("st_resume", 64'({busy, rom_address}), 64'h102);

        // Reset during the LD MEM cycle
        clr_rom();
        rom[0] = 8'h20; rom[1] = 8'h20;
        step(1, 0, 0, 0);
        for (int n = 0; n < 20 && mem_to_reg != 2'b01; n++) step(0, 1, 0, 0);
        chk("mem_reached", 64'(mem_to_reg), 64'd1);
        step(1, 1, 0, 0);
        chk("rst_mem_state", 64'({busy, halted, rom_address}), 64'h000);
        chk("rst_mem_strobes", 64'({n_cs, n_oe, n_we, reg_write}), 64'b1110);

        // Random aligned programs with random run/flags/reset
        for (int a = 0; a < 128; a++) begin
            int unsigned k;
            logic [7:0] b1, b2;
            k  = $urandom_range(0, 99);
            b2 = 8'($urandom);
            if (k < 3)       begin b1 = 8'h50; end
            else if (k < 12) begin b1 = {4'h0, 4'($urandom)}; end
            else if (k < 15) begin b1 = {3'b011, 5'($urandom)}; end
            else if (k < 30) begin b1 = {4'h1, 4'($urandom)}; end
            else if (k < 42) begin b1 = {4'h2, 4'($urandom)}; end
            else if (k < 54) begin b1 = {4'h3, 4'($urandom)}; end
            else if (k < 72) begin
                b1 = jc_tab[$urandom_range(0, 6)] | ($urandom_range(0, 1) ? 8'h08 : 8'h00);
                b2 = {7'($urandom), 1'b0};
            end
            else begin b1 = {1'b1, 7'($urandom)}; end
            rom[2 * a] = b1; rom[2 * a + 1] = b2;
        end
        step(1, 0, 0, 0);
        for (int n = 0; n < 4000; n++) begin
            bit rs;
            rs = m_halted ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 299) == 0);
            step(rs, $urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
